mul_share_arbiter: RTL and testbench

Round-robin arbiter and pipeline controller that shares one combinational 8x8 signed multiplier among NREQ requesters. It accepts operand pairs over per-requester valid/ready handshakes, registers them into an issue stage that drives the shared multiplier, and captures the 16-bit product into a result stage. The result stage returns the product with the requester ID over a single valid/ready response channel. The block sits between requesting datapath blocks and the shared Booth/Wallace multiplier core, which connects through the `mul_*` ports.

---
 rtl/mul_share_arbiter.sv | 146 ++++++++++++++
 tb/tb_mul_share_arbiter.sv | 473 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter
// Round-robin arbiter and two-stage pipeline controller sharing one
// combinational 8x8 signed multiplier among NREQ requesters.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid/req_ready per-requester handshake (ready is one-hot or zero)
//   req_a/req_b         packed signed operands, requester i at [8i+7:8i]
//   mul_a/mul_b/mul_p   shared multiplier core (mul_p combinational)
//   rsp_valid/rsp_ready response handshake
//   rsp_id/rsp_p        owning requester and signed 16-bit product
//   stat_ops/stat_stall saturating response / stall counters
//
// Optional feature: define MUL_SHARE_ARBITER_STATS_EN to build the
// statistics counters; otherwise stat_ops/stat_stall are tied to zero.
module mul_share_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned ID_W = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [8*NREQ-1:0]    req_a,
  input  logic [8*NREQ-1:0]    req_b,
  output logic [7:0]           mul_a,
  output logic [7:0]           mul_b,
  input  logic [15:0]          mul_p,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [15:0]          rsp_p,
  output logic [15:0]          stat_ops,
  output logic [15:0]          stat_stall
);

  localparam int unsigned OP_W = 8;
  localparam int unsigned P_W  = 16;

  // Issue stage (S1)
  logic              r_s1_valid;
  logic [ID_W-1:0]   r_s1_id;
  logic [OP_W-1:0]   r_s1_a;
  logic [OP_W-1:0]   r_s1_b;
  // Result stage (S2)
  logic              r_rsp_valid;
  logic [ID_W-1:0]   r_rsp_id;
  logic [P_W-1:0]    r_rsp_p;
  // Round-robin pointer: last granted requester
  logic [ID_W-1:0]   r_last;

  logic              w_ld1;
  logic              w_ld2;
  logic              w_accept;
  logic [ID_W-1:0]   w_win;
  logic [OP_W-1:0]   w_win_a;
  logic [OP_W-1:0]   w_win_b;

  assign w_ld2 = !r_rsp_valid || rsp_ready;
  assign w_ld1 = !r_s1_valid || w_ld2;

  // Winner search: walk offsets from farthest to nearest so the nearest
  // valid requester after r_last is the final (winning) assignment.
  always_comb begin
    w_win = '0;
    for (int unsigned k = NREQ; k > 0; k--) begin
      if (((req_valid >> ((32'(r_last) + k) % NREQ)) & NREQ'(1)) != '0) begin
        w_win = ID_W'((32'(r_last) + k) % NREQ);
      end
    end
  end

  // Ready is forced low during reset so nothing is accepted then.
  assign w_accept  = rst_n && w_ld1 && (|req_valid);
  assign req_ready = w_accept ? (NREQ'(1) << w_win) : '0;

  assign w_win_a = OP_W'(req_a >> (OP_W * 32'(w_win)));
  assign w_win_b = OP_W'(req_b >> (OP_W * 32'(w_win)));

  // Pipeline state and arbitration pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_id     <= '0;
      r_s1_a      <= '0;
      r_s1_b      <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_p     <= '0;
      r_last      <= ID_W'(NREQ - 1);
    end else begin
      if (w_ld2) begin
        r_rsp_valid <= r_s1_valid;
        r_rsp_id    <= r_s1_id;
        if (r_s1_valid) begin
          r_rsp_p <= mul_p;
        end
      end
      if (w_ld1) begin
        if (w_accept) begin
          r_s1_valid <= 1'b1;
          r_s1_id    <= w_win;
          r_s1_a     <= w_win_a;
          r_s1_b     <= w_win_b;
          r_last     <= w_win;
        end else begin
          // Operands hold so the multiplier inputs do not toggle when idle
          r_s1_valid <= 1'b0;
        end
      end
    end
  end

  assign mul_a     = r_s1_a;
  assign mul_b     = r_s1_b;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_p     = r_rsp_p;

`ifdef MUL_SHARE_ARBITER_STATS_EN
  logic [15:0] r_stat_ops;
  logic [15:0] r_stat_stall;

  // Saturating response and stall counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_ops   <= '0;
      r_stat_stall <= '0;
    end else begin
      if (r_rsp_valid && rsp_ready && (r_stat_ops != 16'hFFFF)) begin
        r_stat_ops <= r_stat_ops + 16'd1;
      end
      if (r_rsp_valid && !rsp_ready && (r_stat_stall != 16'hFFFF)) begin
        r_stat_stall <= r_stat_stall + 16'd1;
      end
    end
  end

  assign stat_ops   = r_stat_ops;
  assign stat_stall = r_stat_stall;
`else
  assign stat_ops   = '0;
  assign stat_stall = '0;
`endif

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Testbench for mul_share_arbiter: scenario tasks compared against a
// transaction-level model (in-flight queue of at most two results).
module tb_mul_share_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned ID_W = 2;

  logic                clk;
  logic                rst_n;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [8*NREQ-1:0]   req_a;
  logic [8*NREQ-1:0]   req_b;
  logic [7:0]          mul_a;
  logic [7:0]          mul_b;
  logic [15:0]         mul_p;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [ID_W-1:0]     rsp_id;
  logic [15:0]         rsp_p;
  logic [15:0]         stat_ops;
  logic [15:0]         stat_stall;

  byte op_a [NREQ];
  byte op_b [NREQ];

  mul_share_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_p(rsp_p),
    .stat_ops(stat_ops), .stat_stall(stat_stall)
  );

  // Shared multiplier core stand-in
  assign mul_p = 16'($signed({{8{mul_a[7]}}, mul_a}) * $signed({{8{mul_b[7]}}, mul_b}));

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_a[8*i +: 8] = op_a[i];
      req_b[8*i +: 8] = op_b[i];
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: results in flight, oldest first; age counts edges since accept
  typedef struct {
    int          id;
    logic [15:0] p;
    int          age;
  } item_t;

  item_t           q[$];
  int              m_last;
  int unsigned     m_ops;
  int unsigned     m_stall;
  logic [NREQ-1:0] exp_ready;
  logic            exp_acc;
  logic            exp_rv;
  int              exp_win;
  logic [15:0]     exp_prod;
  logic [NREQ-1:0] last_acc;
  int              errors = 0;
  int              checks = 0;

  function automatic logic [15:0] ref_mul(byte a, byte b);
    return 16'(int'(a) * int'(b));
  endfunction

  // Two results in flight means both stages are full; accept then needs rsp_ready.
  function automatic void model_eval();
    logic ld1;
    logic found;
    found   = 1'b0;
    exp_win = 0;
    exp_rv  = (q.size() > 0) && (q[0].age >= 1);
    ld1     = (q.size() < 2) || rsp_ready;
    for (int k = 1; k <= int'(NREQ); k++) begin
      int idx;
      idx = (m_last + k) % int'(NREQ);
      if (!found && req_valid[idx]) begin
        found   = 1'b1;
        exp_win = idx;
      end
    end
    exp_acc   = found && ld1 && rst_n;
    exp_ready = exp_acc ? (NREQ'(1) << exp_win) : '0;
    exp_prod  = ref_mul(op_a[exp_win], op_b[exp_win]);
  endfunction

  function automatic void model_reset();
    q.delete();
    m_last  = int'(NREQ) - 1;
    m_ops   = 0;
    m_stall = 0;
  endfunction

  // Cross one rising edge and advance the model; returns at the next falling edge.
  task automatic advance();
    model_eval();
    last_acc = req_valid & req_ready;
    @(posedge clk);
    if (exp_rv && rsp_ready) begin
      void'(q.pop_front());
      if (m_ops < 65535) m_ops++;
    end else if (exp_rv) begin
      if (m_stall < 65535) m_stall++;
    end
    foreach (q[i]) q[i].age++;
    if (exp_acc) begin
      q.push_back('{exp_win, exp_prod, 0});
      m_last = exp_win;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    rsp_ready = 1'b1;
    req_valid = '1;
    for (int i = 0; i < NREQ; i++) begin
      op_a[i] = byte'($urandom);
      op_b[i] = byte'($urandom);
    end
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (req_ready !== '0) begin errors++; $display("FAIL reset_ready: got %b expected 0", req_ready); end
    checks++;
    if (rsp_valid !== 1'b0 || rsp_id !== '0 || rsp_p !== 16'h0) begin
      errors++; $display("FAIL reset_rsp: got v=%b id=%0d p=%h expected 0/0/0000", rsp_valid, rsp_id, rsp_p);
    end
    checks++;
    if (mul_a !== 8'h00 || mul_b !== 8'h00) begin
      errors++; $display("FAIL reset_mul: got a=%h b=%h expected 00/00", mul_a, mul_b);
    end
    checks++;
    if (stat_ops !== 16'h0 || stat_stall !== 16'h0) begin
      errors++; $display("FAIL reset_stats: got %h/%h expected 0/0", stat_ops, stat_stall);
    end
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_single();
    rsp_ready = 1'b1;
    op_a[0]   = -8'sd7;
    op_b[0]   = 8'sd9;
    req_valid = 4'b0001;
    #1; model_eval();
    checks++;
    if (req_ready !== 4'b0001 || req_ready !== exp_ready) begin
      errors++; $display("FAIL single_grant: got %b expected 0001", req_ready);
    end
    advance();
    req_valid = '0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_early: got rsp_valid=%b expected 0", rsp_valid); end
    advance();
    #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_p !== 16'hFFC1) begin
      errors++; $display("FAIL single_rsp: got v=%b id=%0d p=%h expected 1/0/ffc1", rsp_valid, rsp_id, rsp_p);
    end
    advance();
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || q.size() != 0) begin
      errors++; $display("FAIL single_drain: got rsp_valid=%b expected 0", rsp_valid);
    end
    @(negedge clk);
  endtask

  task automatic test_corners();
    byte         ca [3];
    byte         cb [3];
    logic [15:0] cp [3];
    int sent = 0, got = 0, first_c = -1, last_c = -1;
    ca = '{8'sh80, 8'sh7F, 8'sh00};
    cb = '{8'sh80, 8'sh80, 8'shFF};
    cp = '{16'h4000, 16'hC080, 16'h0000};
    rsp_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (sent < 3) begin
        op_a[2] = ca[sent]; op_b[2] = cb[sent]; req_valid = 4'b0100;
      end else begin
        req_valid = '0;
      end
      #1; model_eval();
      checks++;
      if (req_ready !== exp_ready) begin errors++; $display("FAIL corner_ready: got %b expected %b", req_ready, exp_ready); end
      checks++;
      if (rsp_valid !== exp_rv) begin errors++; $display("FAIL corner_valid: got %b expected %b", rsp_valid, exp_rv); end
      if (exp_rv && got < 3) begin
        checks++;
        if (rsp_p !== cp[got] || rsp_id !== 2'd2) begin
          errors++; $display("FAIL corner_p%0d: got id=%0d p=%h expected id=2 p=%h", got, rsp_id, rsp_p, cp[got]);
        end
        if (first_c < 0) first_c = c;
        last_c = c;
        got++;
      end
      advance();
      if (last_acc[2]) sent++;
    end
    checks++;
    if (got != 3 || last_c - first_c != 2) begin
      errors++; $display("FAIL corner_spacing: got %0d results over %0d cycles expected 3 over 2", got, last_c - first_c);
    end
  endtask

  task automatic test_fairness();
    int n = 0;
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      op_a[i] = byte'($urandom); op_b[i] = byte'($urandom);
    end
    req_valid = '1;
    for (int c = 0; c < 14; c++) begin
      if (n >= 8) req_valid = '0;
      #1; model_eval();
      checks++;
      if (req_ready !== exp_ready) begin errors++; $display("FAIL fair_ready: got %b expected %b", req_ready, exp_ready); end
      checks++;
      if (rsp_valid !== exp_rv) begin errors++; $display("FAIL fair_valid: got %b expected %b", rsp_valid, exp_rv); end
      if (exp_rv) begin
        checks++;
        if (rsp_id !== ID_W'(q[0].id) || rsp_p !== q[0].p) begin
          errors++; $display("FAIL fair_rsp: got id=%0d p=%h expected id=%0d p=%h", rsp_id, rsp_p, q[0].id, q[0].p);
        end
      end
      if (req_ready != '0) begin
        checks++;
        if (req_ready !== (NREQ'(1) << (n % int'(NREQ)))) begin
          errors++; $display("FAIL fair_order: got %b expected grant %0d", req_ready, n % int'(NREQ));
        end
      end
      advance();
      for (int i = 0; i < NREQ; i++) begin
        if (last_acc[i]) begin
          n++; op_a[i] = byte'($urandom); op_b[i] = byte'($urandom);
        end
      end
    end
    checks++;
    if (n != 8 || q.size() != 0) begin errors++; $display("FAIL fair_count: got %0d accepts expected 8", n); end
  endtask

  task automatic test_backpressure();
    int          n_acc = 0, n_rsp = 0;
    logic        have_held = 1'b0;
    logic [15:0] held_p;
    logic [ID_W-1:0] held_id;
    rsp_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      op_a[i] = byte'($urandom); op_b[i] = byte'($urandom);
    end
    req_valid = 4'b1011;
    for (int c = 0; c < 5; c++) begin
      #1; model_eval();
      checks++;
      if (req_ready !== exp_ready) begin errors++; $display("FAIL bp_ready: got %b expected %b", req_ready, exp_ready); end
      if (c >= 2) begin
        checks++;
        if (req_ready !== '0) begin errors++; $display("FAIL bp_blocked: got %b expected 0", req_ready); end
      end
      if (have_held) begin
        checks++;
        if (rsp_valid !== 1'b1 || rsp_p !== held_p || rsp_id !== held_id) begin
          errors++; $display("FAIL bp_hold: got v=%b id=%0d p=%h expected 1/%0d/%h", rsp_valid, rsp_id, rsp_p, held_id, held_p);
        end
      end else if (rsp_valid) begin
        have_held = 1'b1; held_p = rsp_p; held_id = rsp_id;
      end
      advance();
      if (last_acc != '0) n_acc++;
      req_valid = req_valid & ~last_acc;
    end
    checks++;
    if (n_acc != 2) begin errors++; $display("FAIL bp_accepts: got %0d expected 2", n_acc); end
    rsp_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1; model_eval();
      checks++;
      if (req_ready !== exp_ready) begin errors++; $display("FAIL bp_rel_ready: got %b expected %b", req_ready, exp_ready); end
      checks++;
      if (rsp_valid !== exp_rv) begin errors++; $display("FAIL bp_rel_valid: got %b expected %b", rsp_valid, exp_rv); end
      if (exp_rv) begin
        checks++;
        if (rsp_id !== ID_W'(q[0].id) || rsp_p !== q[0].p) begin
          errors++; $display("FAIL bp_drain: got id=%0d p=%h expected id=%0d p=%h", rsp_id, rsp_p, q[0].id, q[0].p);
        end
        n_rsp++;
      end
      advance();
      req_valid = req_valid & ~last_acc;
    end
    checks++;
    if (n_rsp != 3 || q.size() != 0 || req_valid != '0) begin
      errors++; $display("FAIL bp_total: got %0d responses expected 3", n_rsp);
    end
  endtask

  task automatic test_reset_midstream();
    int first_id = -1;
    rsp_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      op_a[i] = byte'($urandom); op_b[i] = byte'($urandom);
    end
    req_valid = 4'b1010;
    for (int c = 0; c < 3; c++) begin
      advance();
      req_valid = req_valid & ~last_acc;
    end
    #1;
    checks++;
    if (rsp_valid !== 1'b1 || q.size() != 2) begin
      errors++; $display("FAIL mid_full: got rsp_valid=%b expected 1 with both stages full", rsp_valid);
    end
    rst_n     = 1'b0;
    req_valid = 4'b0101;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_p !== 16'h0 || req_ready !== '0) begin
      errors++; $display("FAIL mid_reset: got v=%b p=%h ready=%b expected 0/0000/0", rsp_valid, rsp_p, req_ready);
    end
    model_reset();
    @(negedge clk);
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1; model_eval();
      if (c == 0) begin
        checks++;
        if (req_ready !== 4'b0001) begin errors++; $display("FAIL mid_first_grant: got %b expected 0001", req_ready); end
      end
      checks++;
      if (req_ready !== exp_ready) begin errors++; $display("FAIL mid_ready: got %b expected %b", req_ready, exp_ready); end
      if (exp_rv) begin
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== ID_W'(q[0].id) || rsp_p !== q[0].p) begin
          errors++; $display("FAIL mid_rsp: got id=%0d p=%h expected id=%0d p=%h", rsp_id, rsp_p, q[0].id, q[0].p);
        end
        if (first_id < 0) first_id = int'(rsp_id);
      end
      advance();
      req_valid = req_valid & ~last_acc;
    end
    checks++;
    if (first_id != 0 || q.size() != 0) begin errors++; $display("FAIL mid_order: got first id %0d expected 0", first_id); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 410; c++) begin
      if (c < 400) begin
        for (int i = 0; i < NREQ; i++) begin
          if (!req_valid[i] && ($urandom_range(1, 0) == 1)) begin
            req_valid[i] = 1'b1; op_a[i] = byte'($urandom); op_b[i] = byte'($urandom);
          end
        end
        rsp_ready = ($urandom_range(3, 0) != 0);
      end else begin
        rsp_ready = 1'b1;
      end
      #1; model_eval();
      checks++;
      if (req_ready !== exp_ready) begin errors++; $display("FAIL rand_ready: got %b expected %b", req_ready, exp_ready); end
      checks++;
      if (rsp_valid !== exp_rv) begin errors++; $display("FAIL rand_valid: got %b expected %b", rsp_valid, exp_rv); end
      if (exp_rv) begin
        checks++;
        if (rsp_id !== ID_W'(q[0].id) || rsp_p !== q[0].p) begin
          errors++; $display("FAIL rand_rsp: got id=%0d p=%h expected id=%0d p=%h", rsp_id, rsp_p, q[0].id, q[0].p);
        end
      end
      advance();
      req_valid = req_valid & ~last_acc;
    end
    checks++;
    if (q.size() != 0 || req_valid != '0) begin
      errors++; $display("FAIL rand_drain: got %0d in flight, valid=%b expected 0", q.size(), req_valid);
    end
  endtask

  task automatic test_stats();
    int          issued = 0, stalls = 0;
    logic [15:0] want_ops, want_stall;
    do_reset();
    for (int c = 0; c < 60 && m_ops < 10; c++) begin
      req_valid = (issued < 10) ? 4'b0010 : 4'b0000;
      rsp_ready = 1'b1;
      #1; model_eval();
      if (exp_rv && stalls < 3 && issued >= 4) begin
        rsp_ready = 1'b0; stalls++;
      end
      #1; model_eval();
      checks++;
      if (req_ready !== exp_ready) begin errors++; $display("FAIL stats_ready: got %b expected %b", req_ready, exp_ready); end
      if (exp_rv) begin
        checks++;
        if (rsp_valid !== 1'b1 || rsp_p !== q[0].p) begin
          errors++; $display("FAIL stats_rsp: got v=%b p=%h expected 1/%h", rsp_valid, rsp_p, q[0].p);
        end
      end
      advance();
      if (last_acc[1]) begin
        issued++; op_a[1] = byte'($urandom); op_b[1] = byte'($urandom);
      end
    end
    checks++;
    if (m_ops != 10 || m_stall != 3) begin
      errors++; $display("FAIL stats_run: got %0d ops %0d stalls expected 10/3", m_ops, m_stall);
    end
`ifdef MUL_SHARE_ARBITER_STATS_EN
    want_ops   = 16'd10;
    want_stall = 16'd3;
`else
    want_ops   = 16'd0;
    want_stall = 16'd0;
`endif
    #1;
    checks++;
    if (stat_ops !== want_ops) begin errors++; $display("FAIL stat_ops: got %0d expected %0d", stat_ops, want_ops); end
    checks++;
    if (stat_stall !== want_stall) begin errors++; $display("FAIL stat_stall: got %0d expected %0d", stat_stall, want_stall); end
    @(negedge clk);
  endtask

  initial begin
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    req_valid = '0;
    for (int i = 0; i < NREQ; i++) begin
      op_a[i] = 8'sd0; op_b[i] = 8'sd0;
    end
    model_reset();
    #2;
    test_reset();
    test_single();
    test_corners();
    test_fairness();
    test_backpressure();
    test_reset_midstream();
    test_random();
    test_stats();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
